// File: rtl/bdc_pkg.sv
// Shared types and constants for the barrel distortion corrector.
// Q8.8 fixed point is used throughout for the radial scale factor.
// calc_norm() maps the largest squared radius of the frame onto 2^16.
package bdc_pkg;

  localparam int FRAC_BITS  = 8;
  localparam int NORM_SHIFT = 24;
  localparam int ONE_Q88    = 1 << FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // floor(2^24 / ((width/2)^2 + (height/2)^2))
  function automatic longint calc_norm(input int width, input int height);
    longint half_w;
    longint half_h;
    half_w = longint'(width / 2);
    half_h = longint'(height / 2);
    return (longint'(1) <<< NORM_SHIFT) / (half_w * half_w + half_h * half_h);
  endfunction

endpackage

// File: rtl/bdc_coord_map.sv
// Maps an output raster coordinate to its clamped source coordinate.
// Latency: 4 cycles, i_vld -> o_vld.
// Backpressure: every stage holds while i_adv is low.
// Ports: clk/rst; i_adv advances the pipe; i_vld/i_x/i_y/i_side is the
//   coordinate issue; o_vld/o_sx/o_sy/o_side is the source coordinate and
//   the sideband (bit0 first pixel, bit1 last pixel) carried alongside.
module bdc_coord_map
  import bdc_pkg::*;
#(
  parameter int          WIDTH  = 640,
  parameter int          HEIGHT = 480,
  parameter logic [15:0] K1     = 16'h0100,
  parameter logic [15:0] K2     = 16'h0020,
  parameter int          CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic          i_vld,
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [1:0]    i_side,
  output logic          o_vld,
  output logic [CW-1:0] o_sx,
  output logic [CW-1:0] o_sy,
  output logic [1:0]    o_side
);

  localparam int     HW   = WIDTH / 2;
  localparam int     HH   = HEIGHT / 2;
  localparam longint NORM = calc_norm(WIDTH, HEIGHT);

  // r2n tops out at 2^16, r4n at 2^24, so scale needs about 34 bits.
  localparam int R2W = 2 * CW + 2;
  localparam int RNW = 17;
  localparam int SCW = 36;

  logic [3:0]            r_vld;
  logic [3:0][1:0]       r_side;
  logic signed [CW:0]    r1_dx, r1_dy, r2_dx, r2_dy, r3_dx, r3_dy;
  logic [R2W-1:0]        r1_r2;
  logic [RNW-1:0]        r2_r2n;
  logic [SCW-1:0]        r3_scale;
  logic [CW-1:0]         r4_sx, r4_sy;

  longint        w_dx, w_dy, w_r2, w_r2n, w_r4n, w_scale, w_sx, w_sy;
  logic [CW-1:0] w_sx_c, w_sy_c;

  always_comb begin
    // stage 1: centred offsets and squared radius
    w_dx    = longint'(i_x) - longint'(HW);
    w_dy    = longint'(i_y) - longint'(HH);
    w_r2    = w_dx * w_dx + w_dy * w_dy;
    // stage 2: normalised radius
    w_r2n   = (longint'(r1_r2) * NORM) >> FRAC_BITS;
    // stage 3: polynomial scale 1 + K1*r2n + K2*r4n
    w_r4n   = (longint'(r2_r2n) * longint'(r2_r2n)) >> FRAC_BITS;
    w_scale = longint'(ONE_Q88)
            + ((longint'(K1) * longint'(r2_r2n)) >> FRAC_BITS)
            + ((longint'(K2) * w_r4n) >> FRAC_BITS);
    // stage 4: scaled source position, arithmetic shift keeps the sign
    w_sx    = longint'(HW) + ((longint'(r3_dx) * longint'(r3_scale)) >>> FRAC_BITS);
    w_sy    = longint'(HH) + ((longint'(r3_dy) * longint'(r3_scale)) >>> FRAC_BITS);

    w_sx_c = CW'(w_sx);
    if (w_sx < 0)                          w_sx_c = '0;
    else if (w_sx > longint'(WIDTH - 1))   w_sx_c = CW'(WIDTH - 1);
    w_sy_c = CW'(w_sy);
    if (w_sy < 0)                          w_sy_c = '0;
    else if (w_sy > longint'(HEIGHT - 1))  w_sy_c = CW'(HEIGHT - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (i_adv) begin
      r_vld <= {r_vld[2:0], i_vld};
    end
  end

  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_side   <= {r_side[2:0], i_side};
      r1_dx    <= (CW + 1)'(w_dx);
      r1_dy    <= (CW + 1)'(w_dy);
      r1_r2    <= R2W'(w_r2);
      r2_dx    <= r1_dx;
      r2_dy    <= r1_dy;
      r2_r2n   <= RNW'(w_r2n);
      r3_dx    <= r2_dx;
      r3_dy    <= r2_dy;
      r3_scale <= SCW'(w_scale);
      r4_sx    <= w_sx_c;
      r4_sy    <= w_sy_c;
    end
  end

  assign o_vld  = r_vld[3];
  assign o_side = r_side[3];
  assign o_sx   = r4_sx;
  assign o_sy   = r4_sy;

endmodule

// File: rtl/barrel_distortion_correction.sv
// Frame-buffered barrel distortion corrector on AXI4-Stream video.
// Latency: 5 cycles from coordinate issue to m_axis_tvalid; 1 pixel/clk.
// Backpressure: s_axis_tready low while draining; whole pipe stalls on !m_axis_tready.
// Ports: clk/rst (sync, active-high); s_axis_* input frame (tuser=SOF,
//   tlast=EOF); m_axis_* corrected frame (tuser on (0,0), tlast on last pixel).
module barrel_distortion_correction
  import bdc_pkg::*;
#(
  parameter int          WIDTH         = 640,
  parameter int          HEIGHT        = 480,
  parameter int          DATA_WIDTH    = 24,
  parameter logic [15:0] DISTORTION_K1 = 16'h0100,
  parameter logic [15:0] DISTORTION_K2 = 16'h0020,
  parameter int          BUFFER_LINES  = HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready
);

  localparam int PIX   = WIDTH * HEIGHT;
  localparam int DEPTH = WIDTH * BUFFER_LINES;
  localparam int CNTW  = $clog2(PIX);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1;

  state_t                r_state, w_next_state;
  logic [CNTW-1:0]       r_wr_idx, w_wr_idx;
  logic                  w_s_rdy, w_in_hs, w_wr_en, w_last_beat, w_store_en;
  logic [AW-1:0]         w_wr_addr, w_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [CW-1:0]         r_ix, r_iy;
  logic                  r_issue_done;
  logic                  w_issue_vld, w_adv, w_ix_last, w_iy_last;
  logic [1:0]            w_side;

  logic                  w_cm_vld;
  logic [CW-1:0]         w_cm_sx, w_cm_sy;
  logic [1:0]            w_cm_side;
  logic                  w_rd_ok;

  logic                  r_m_vld, r_m_last, r_m_user;
  logic [DATA_WIDTH-1:0] r_m_dat;
  logic                  w_m_hs;

  assign w_s_rdy = (r_state != DRAIN);
  assign w_in_hs = s_axis_tvalid && w_s_rdy;
  assign w_m_hs  = r_m_vld && m_axis_tready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    // SOF always restarts the raster at address 0
    w_wr_idx     = s_axis_tuser ? '0 : r_wr_idx;
    w_last_beat  = s_axis_tlast || (w_wr_idx == CNTW'(PIX - 1));
    case (r_state)
      IDLE: begin
        if (w_in_hs && s_axis_tuser) begin
          w_wr_en      = 1'b1;
          w_next_state = w_last_beat ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (w_in_hs) begin
          w_wr_en      = 1'b1;
          w_next_state = w_last_beat ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (w_m_hs && r_m_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          r_wr_idx <= '0;
    else if (w_wr_en) r_wr_idx <= w_wr_idx + 1'b1;
  end

  // ---------------- frame store ----------------
  // Lines beyond BUFFER_LINES are accepted but dropped.
  assign w_store_en = w_wr_en && (32'(w_wr_idx) < DEPTH);
  assign w_wr_addr  = AW'(w_wr_idx);

  always_ff @(posedge clk) begin
    if (w_store_en) r_mem[w_wr_addr] <= s_axis_tdata;
  end

  // ---------------- coordinate issue ----------------
  assign w_adv       = !(r_m_vld && !m_axis_tready);
  assign w_issue_vld = (r_state == DRAIN) && !r_issue_done;
  assign w_ix_last   = (r_ix == CW'(WIDTH - 1));
  assign w_iy_last   = (r_iy == CW'(HEIGHT - 1));
  assign w_side      = {w_ix_last && w_iy_last, (r_ix == '0) && (r_iy == '0)};

  // Held at zero outside DRAIN so each drain starts at (0,0).
  always_ff @(posedge clk) begin
    if (rst || (r_state != DRAIN)) begin
      r_ix         <= '0;
      r_iy         <= '0;
      r_issue_done <= 1'b0;
    end else if (w_adv && w_issue_vld) begin
      if (w_ix_last) begin
        r_ix <= '0;
        if (w_iy_last) r_issue_done <= 1'b1;
        else           r_iy <= r_iy + 1'b1;
      end else begin
        r_ix <= r_ix + 1'b1;
      end
    end
  end

  bdc_coord_map #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .K1     (DISTORTION_K1),
    .K2     (DISTORTION_K2),
    .CW     (CW)
  ) u_coord_map (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (w_adv),
    .i_vld  (w_issue_vld),
    .i_x    (r_ix),
    .i_y    (r_iy),
    .i_side (w_side),
    .o_vld  (w_cm_vld),
    .o_sx   (w_cm_sx),
    .o_sy   (w_cm_sy),
    .o_side (w_cm_side)
  );

  // ---------------- read + AXIS output register ----------------
  assign w_rd_ok   = (32'(w_cm_sy) < BUFFER_LINES);
  assign w_rd_addr = w_rd_ok ? AW'(32'(w_cm_sy) * WIDTH + 32'(w_cm_sx)) : '0;

  // The synchronous RAM read doubles as the output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_vld  <= 1'b0;
      r_m_user <= 1'b0;
      r_m_last <= 1'b0;
      r_m_dat  <= '0;
    end else if (w_adv) begin
      r_m_vld  <= w_cm_vld;
      r_m_user <= w_cm_vld && w_cm_side[0];
      r_m_last <= w_cm_vld && w_cm_side[1];
      r_m_dat  <= w_rd_ok ? r_mem[w_rd_addr] : '0;
    end
  end

  assign s_axis_tready = w_s_rdy;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tuser  = r_m_user;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tdata  = r_m_dat;

endmodule

// File: tb/tb_barrel_distortion_correction.sv
// Bench for barrel_distortion_correction at 32x16, default K and K1=K2=0.
// Two instances share the input stream; outputs compared to a frame model.
// Downstream ready is driven either constantly high or pseudo-randomly.
module tb_barrel_distortion_correction;

  localparam int     W      = 32;
  localparam int     H      = 16;
  localparam int     BL     = 16;
  localparam int     N      = W * H;
  localparam int     HW     = W / 2;
  localparam int     HH     = H / 2;
  localparam longint NORM_M = 64'sd16777216 / longint'(HW * HW + HH * HH);
  localparam longint KD1    = 256;
  localparam longint KD2    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic        s_tready, s_tready0;
  logic [23:0] m_tdata, m_tdata0;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tvalid0, m_tlast0, m_tuser0;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  barrel_distortion_correction #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24),
    .DISTORTION_K1(16'h0100), .DISTORTION_K2(16'h0020), .BUFFER_LINES(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready)
  );

  barrel_distortion_correction #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(24),
    .DISTORTION_K1(16'h0000), .DISTORTION_K2(16'h0000), .BUFFER_LINES(BL)
  ) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
    .m_axis_tuser(m_tuser0), .m_axis_tready(m_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int frame_in  [N];
  int mem_model [N];
  int got_d[$], got0_d[$], ref_t1[$];
  bit got_u[$], got_l[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: radial model on the stored frame, plain integer arithmetic.
  function automatic int exp_pix(input int i, input longint k1, input longint k2);
    longint dx, dy, r2, r2n, r4n, sc, sx, sy;
    dx  = longint'(i % W) - HW;
    dy  = longint'(i / W) - HH;
    r2  = dx * dx + dy * dy;
    r2n = (r2 * NORM_M) >> 8;
    r4n = (r2n * r2n) >> 8;
    sc  = 256 + ((k1 * r2n) >> 8) + ((k2 * r4n) >> 8);
    sx  = HW + ((dx * sc) >>> 8);
    sy  = HH + ((dy * sc) >>> 8);
    if (sx < 0) sx = 0;
    if (sx > W - 1) sx = W - 1;
    if (sy < 0) sy = 0;
    if (sy > H - 1) sy = H - 1;
    if (sy >= BL) return 0;
    return mem_model[int'(sy) * W + int'(sx)];
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic beat(input int d, input bit u, input bit l);
    int guard;
    s_tdata = d[23:0]; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!s_tready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("s_tready_wait", {63'd0, s_tready}, 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int junk);
    for (int j = 0; j < junk; j++) begin
      beat(int'($urandom & 32'hFFFFFF), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < nbeats; i++) begin
      beat(frame_in[i], i == 0, i == last_at);
      mem_model[i] = frame_in[i];
      if (i != nbeats - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic collect(input int n, input bit rnd);
    int cyc;
    bit pst;
    logic [23:0] pd;
    bit pu, pl;
    got_d.delete(); got0_d.delete(); got_u.delete(); got_l.delete();
    cyc = 0; pst = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
    while (got_d.size() < n && cyc < 20000) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pst) begin
        chk("stall_vld",  {63'd0, m_tvalid}, 64'd1);
        chk("stall_dat",  {40'd0, m_tdata},  {40'd0, pd});
        chk("stall_user", {63'd0, m_tuser},  {63'd0, pu});
        chk("stall_last", {63'd0, m_tlast},  {63'd0, pl});
      end
      pst = m_tvalid && !m_tready;
      pd = m_tdata; pu = m_tuser; pl = m_tlast;
      if (m_tvalid && m_tready) begin
        got_d.push_back(int'(m_tdata));
        got_u.push_back(m_tuser);
        got_l.push_back(m_tlast);
      end
      if (m_tvalid0 && m_tready) got0_d.push_back(int'(m_tdata0));
      @(posedge clk); #1;
      cyc++;
    end
    m_tready = 1'b1;
    chk("out_count",  64'(got_d.size()),  64'(n));
    chk("out_count0", 64'(got0_d.size()), 64'(n));
  endtask

  task automatic check_frame(input string tag);
    int nu, nl;
    nu = 0; nl = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("%s_pix[%0d]", tag, i), 64'(got_d[i]), 64'(exp_pix(i, KD1, KD2)));
      nu += int'(got_u[i]);
      nl += int'(got_l[i]);
    end
    for (int i = 0; i < got0_d.size(); i++)
      chk($sformatf("%s_pix0[%0d]", tag, i), 64'(got0_d[i]), 64'(exp_pix(i, 0, 0)));
    chk({tag, "_tuser_first"}, {63'd0, got_u[0]}, 64'd1);
    chk({tag, "_tlast_last"},  {63'd0, got_l[N-1]}, 64'd1);
    chk({tag, "_tuser_count"}, 64'(nu), 64'd1);
    chk({tag, "_tlast_count"}, 64'(nl), 64'd1);
  endtask

  initial begin
    int k, nz;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", {63'd0, s_tready},  64'd1);
    chk("rst_m_tvalid", {63'd0, m_tvalid},  64'd0);
    chk("rst_m_tuser",  {63'd0, m_tuser},   64'd0);
    chk("rst_m_tlast",  {63'd0, m_tlast},   64'd0);
    chk("rst_m_tdata",  {40'd0, m_tdata},   64'd0);
    chk("rst_m_tvalid0",{63'd0, m_tvalid0}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- 1: checkerboard, junk before SOF, frame ends on beat count ----
    for (int i = 0; i < N; i++)
      frame_in[i] = ((((i % W) / 8) + ((i / W) / 8)) % 2 == 0) ? 32'hFFFFFF : 0;
    send_frame(N, -1, 3);
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (m_tvalid) begin
        k = c;
        break;
      end
    end
    chk("latency", 64'(k), 64'd5);
    collect(N, 1'b0);
    check_frame("t1");
    nz = 0;
    foreach (got_d[i]) if (got_d[i] != 0) nz++;
    chk("t1_nonzero_gt128", {63'd0, nz > 128}, 64'd1);
    ref_t1 = got_d;

    // ---- 2: ramp, identity through the K=0 instance ----
    for (int i = 0; i < N; i++) frame_in[i] = i;
    send_frame(N, N - 1, 0);
    collect(N, 1'b0);
    check_frame("t2");
    for (int i = 0; i < got0_d.size(); i++)
      chk($sformatf("t2_ramp[%0d]", i), 64'(got0_d[i]), 64'(i));

    // ---- 3: centre and corner pixels ----
    for (int i = 0; i < N; i++) frame_in[i] = int'($urandom & 32'hFFFFFF);
    frame_in[8 * W + 16] = 32'hABCDEF;
    frame_in[0]          = 32'h123456;
    send_frame(N, N - 1, 0);
    collect(N, 1'b0);
    check_frame("t3");
    chk("t3_centre", 64'(got_d[8 * W + 16]), 64'hABCDEF);
    chk("t3_corner", 64'(got_d[0]),          64'h123456);

    // ---- 4: checkerboard again with random downstream ready ----
    for (int i = 0; i < N; i++)
      frame_in[i] = ((((i % W) / 8) + ((i / W) / 8)) % 2 == 0) ? 32'hFFFFFF : 0;
    send_frame(N, N - 1, 0);
    collect(N, 1'b1);
    check_frame("t4");
    for (int i = 0; i < got_d.size(); i++)
      chk($sformatf("t4_vs_t1[%0d]", i), 64'(got_d[i]), 64'(ref_t1[i]));

    // ---- 5: early tlast after 100 beats, rest of the store is kept ----
    for (int i = 0; i < N; i++) frame_in[i] = int'($urandom & 32'hFFFFFF);
    send_frame(100, 99, 0);
    chk("t5_s_tready_drain", {63'd0, s_tready}, 64'd0);
    collect(N, 1'b0);
    check_frame("t5");

    // ---- 6: reset in the middle of DRAIN, then a clean frame ----
    for (int i = 0; i < N; i++) frame_in[i] = int'($urandom & 32'hFFFFFF);
    send_frame(N, N - 1, 0);
    collect(20, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("t6_s_tready", {63'd0, s_tready}, 64'd1);
    chk("t6_m_tdata",  {40'd0, m_tdata},  64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) frame_in[i] = int'($urandom & 32'hFFFFFF);
    send_frame(N, N - 1, 0);
    collect(N, 1'b1);
    check_frame("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
